// File: rtl/ice40_audio_fc_seq_if.sv
// Bundle of sequencer control, configuration and status signals for the
// FC layer control unit. The sequencer owns the slave side; whoever drives
// start/config/abort owns the master side.
//
// Handshake: o_rd_req is held high for the whole time the sequencer waits in
// INIT_BIAS. The input buffer answers with i_rd_rdy. The sequencer leaves
// INIT_BIAS on the first rising clock edge at which o_rd_req and i_rd_rdy are
// both high. i_rd_rdy has no effect while o_rd_req is low.
interface ice40_audio_fc_seq_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 6,
    parameter int BLK_W  = 8,
    parameter int CYC_W  = 32
);
    logic              i_start;
    logic              i_repeat_run;
    logic              i_abort;
    logic [DATA_W-1:0] i_cfg_num_data;
    logic [CNT_W-1:0]  i_cfg_num_round;
    logic [CNT_W-1:0]  i_cfg_num_chunk;
    logic [1:0]        i_cfg_num_plane;
    logic [BLK_W-1:0]  i_cfg_stride;
    logic [BLK_W-1:0]  i_blk_idx;
    logic              i_rd_rdy;
    logic              o_rd_req;
    logic [BLK_W-1:0]  o_blk_idx;
    logic [CYC_W-1:0]  o_cycles;
    logic [CNT_W-1:0]  o_bias_addr;
    logic              o_init;
    logic              o_rst_raddr;
    logic              o_rst_waddr;
    logic              o_rst_wgt_addr;
    logic              o_fc_run;
    logic              o_input_rd;
    logic              o_wgt_rd;
    logic              o_init_bias;
    logic              o_fc_ps_shift;
    logic              o_busy;
    logic              o_done;
    logic              o_aborted;
    logic [2:0]        dbg_state;

    modport master (
        output i_start, i_repeat_run, i_abort, i_cfg_num_data, i_cfg_num_round,
               i_cfg_num_chunk, i_cfg_num_plane, i_cfg_stride, i_blk_idx, i_rd_rdy,
        input  o_rd_req, o_blk_idx, o_cycles, o_bias_addr, o_init, o_rst_raddr,
               o_rst_waddr, o_rst_wgt_addr, o_fc_run, o_input_rd, o_wgt_rd,
               o_init_bias, o_fc_ps_shift, o_busy, o_done, o_aborted, dbg_state
    );

    modport slave (
        input  i_start, i_repeat_run, i_abort, i_cfg_num_data, i_cfg_num_round,
               i_cfg_num_chunk, i_cfg_num_plane, i_cfg_stride, i_blk_idx, i_rd_rdy,
        output o_rd_req, o_blk_idx, o_cycles, o_bias_addr, o_init, o_rst_raddr,
               o_rst_waddr, o_rst_wgt_addr, o_fc_run, o_input_rd, o_wgt_rd,
               o_init_bias, o_fc_ps_shift, o_busy, o_done, o_aborted, dbg_state
    );
endinterface

// File: rtl/ice40_audio_fc_seq.sv
// Control sequencer for the keyword-spotting FC MAC array. Walks
// plane/chunk/round loops with runtime bounds latched at start, issues bias
// init, input/weight read strobes and partial-sum shift pulses, and reports
// busy/done/aborted status plus a busy-cycle count.
module ice40_audio_fc_seq #(
    parameter int DATA_W       = 12,
    parameter int CNT_W        = 6,
    parameter int BLK_W        = 8,
    parameter int NUM_OUTPUT   = 1,
    parameter int POST_GAP     = 2,
    parameter int START_OFFSET = 130,
    parameter int PLANE_OFFSET = 128,
    parameter int CYC_W        = 32
) (
    input  logic clk,
    input  logic reset,
    ice40_audio_fc_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INIT_BIAS  = 3'd1;
    localparam logic [2:0] S_RUN_ROUND  = 3'd2;
    localparam logic [2:0] S_RST_ADDR   = 3'd3;
    localparam logic [2:0] S_NEXT_CHUNK = 3'd4;
    localparam logic [2:0] S_NEXT_PLANE = 3'd5;
    localparam logic [2:0] S_WAIT_WRITE = 3'd6;
    localparam logic [2:0] S_HOLD       = 3'd7;

    localparam logic [3:0]       DRAIN_LOAD = 4'(NUM_OUTPUT + POST_GAP);
    localparam logic [3:0]       NUM_OUT4   = 4'(NUM_OUTPUT);
    localparam logic [BLK_W-1:0] START_OFF  = BLK_W'(START_OFFSET);
    localparam logic [BLK_W-1:0] PLANE_OFF  = BLK_W'(PLANE_OFFSET);
    localparam logic [DATA_W:0]  TWO        = 2;

    logic [2:0]        state, state_nxt;
    logic [DATA_W-1:0] num_data;
    logic [CNT_W-1:0]  num_round, num_chunk;
    logic [1:0]        num_plane;
    logic [BLK_W-1:0]  stride, start_blk;
    // One bit wider than num_data so num_data+2 never wraps
    logic [DATA_W:0]   data_cnt;
    logic [CNT_W-1:0]  round_cnt, chunk_cnt;
    logic [1:0]        plane_cnt;
    logic [3:0]        output_cnt;
    logic [BLK_W-1:0]  blk_idx;
    logic [CYC_W-1:0]  cycles;
    logic [CNT_W-1:0]  bias_addr;
    logic              input_rd, wgt_rd, init_bias, ps_shift, aborted;
    logic              busy, start_acc, abort_hit, round_done;

    assign busy       = (state != S_IDLE) && (state != S_HOLD);
    assign start_acc  = (state == S_IDLE) && bus.i_start;
    assign abort_hit  = busy && bus.i_abort;
    assign round_done = (state == S_RUN_ROUND) && (data_cnt == ({1'b0, num_data} + TWO));

    // Next-state selection; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (bus.i_start) state_nxt = S_INIT_BIAS;
            S_INIT_BIAS:  if (bus.i_rd_rdy) state_nxt = S_RUN_ROUND;
            S_RUN_ROUND:  if (round_done)
                              state_nxt = (round_cnt == num_round) ? S_NEXT_CHUNK : S_RST_ADDR;
            S_RST_ADDR:   state_nxt = S_INIT_BIAS;
            S_NEXT_CHUNK: state_nxt = (chunk_cnt == num_chunk) ? S_NEXT_PLANE : S_INIT_BIAS;
            S_NEXT_PLANE: state_nxt = (plane_cnt == num_plane) ? S_WAIT_WRITE : S_INIT_BIAS;
            S_WAIT_WRITE: if (output_cnt == 4'd0) state_nxt = S_HOLD;
            S_HOLD:       if (!(bus.i_start && !bus.i_repeat_run)) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Latch run configuration once at start so mid-run config changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            num_data  <= '0;
            num_round <= '0;
            num_chunk <= '0;
            num_plane <= '0;
            stride    <= '0;
            start_blk <= '0;
        end else if (start_acc) begin
            num_data  <= (bus.i_cfg_num_data == '0) ? {{(DATA_W-1){1'b0}}, 1'b1}
                                                    : bus.i_cfg_num_data;
            num_round <= bus.i_cfg_num_round;
            num_chunk <= bus.i_cfg_num_chunk;
            num_plane <= bus.i_cfg_num_plane;
            stride    <= bus.i_cfg_stride;
            start_blk <= bus.i_blk_idx;
        end
    end

    // Loop counters and output drain counter
    always_ff @(posedge clk) begin
        if (reset) begin
            data_cnt   <= '0;
            round_cnt  <= '0;
            chunk_cnt  <= '0;
            plane_cnt  <= '0;
            output_cnt <= '0;
        end else begin
            if (state == S_IDLE || state == S_INIT_BIAS) data_cnt <= '0;
            else if (state == S_RUN_ROUND)               data_cnt <= data_cnt + 1'b1;

            if (state == S_IDLE || state == S_NEXT_CHUNK) round_cnt <= '0;
            else if (state == S_RST_ADDR)                 round_cnt <= round_cnt + 1'b1;

            if (state == S_IDLE || state == S_NEXT_PLANE) chunk_cnt <= '0;
            else if (state == S_NEXT_CHUNK)               chunk_cnt <= chunk_cnt + 1'b1;

            if (state == S_IDLE)            plane_cnt <= '0;
            else if (state == S_NEXT_PLANE) plane_cnt <= plane_cnt + 1'b1;

            if (abort_hit)                  output_cnt <= '0;
            else if (round_done)            output_cnt <= DRAIN_LOAD;
            else if (output_cnt != 4'd0)    output_cnt <= output_cnt - 4'd1;
        end
    end

    // Read block index, busy-cycle counter and bias address
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_idx   <= '0;
            cycles    <= '0;
            bias_addr <= '0;
        end else begin
            if (start_acc)                  blk_idx <= bus.i_blk_idx - START_OFF;
            else if (state == S_NEXT_CHUNK) blk_idx <= blk_idx + stride;
            else if (state == S_NEXT_PLANE) blk_idx <= start_blk - PLANE_OFF;

            if (start_acc)                  cycles <= '0;
            else if (busy && !abort_hit)    cycles <= cycles + 1'b1;

            if (state == S_IDLE)            bias_addr <= '0;
            else if (init_bias)             bias_addr <= bias_addr + 1'b1;
        end
    end

    // Registered strobes: read window of num_data cycles, shift pulses, abort pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            input_rd  <= 1'b0;
            wgt_rd    <= 1'b0;
            init_bias <= 1'b0;
            ps_shift  <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            init_bias <= (state == S_INIT_BIAS);
            aborted   <= abort_hit;
            ps_shift  <= !abort_hit && (output_cnt != 4'd0) && (output_cnt <= NUM_OUT4);
            if (abort_hit || state != S_RUN_ROUND) begin
                input_rd <= 1'b0;
                wgt_rd   <= 1'b0;
            end else if (data_cnt == {1'b0, num_data}) begin
                input_rd <= 1'b0;
                wgt_rd   <= 1'b0;
            end else if (data_cnt == '0) begin
                input_rd <= 1'b1;
                wgt_rd   <= 1'b1;
            end
        end
    end

    assign bus.o_rd_req       = (state == S_INIT_BIAS);
    assign bus.o_fc_run       = (state == S_RUN_ROUND);
    assign bus.o_busy         = busy;
    assign bus.o_done         = (state == S_HOLD);
    assign bus.o_init         = (state == S_IDLE);
    assign bus.o_rst_raddr    = (state == S_IDLE) || (state == S_RST_ADDR);
    assign bus.o_rst_waddr    = (state == S_IDLE) || ((state == S_WAIT_WRITE) && (output_cnt == 4'd0));
    assign bus.o_rst_wgt_addr = (state == S_IDLE) || (state == S_NEXT_CHUNK);
    assign bus.o_blk_idx      = blk_idx;
    assign bus.o_cycles       = cycles;
    assign bus.o_bias_addr    = bias_addr;
    assign bus.o_input_rd     = input_rd;
    assign bus.o_wgt_rd       = wgt_rd;
    assign bus.o_init_bias    = init_bias;
    assign bus.o_fc_ps_shift  = ps_shift;
    assign bus.o_aborted      = aborted;
    assign bus.dbg_state      = state;
endmodule

// File: tb/tb_ice40_audio_fc_seq.sv
// Bench for ice40_audio_fc_seq: directed scenarios plus randomized runs.
// Expected per-round and per-run results are computed from the loop rules
// and queued when a run is launched; a monitor pops them as the DUT shows
// round ends and run completion.
module tb_ice40_audio_fc_seq;
    localparam int NUM_OUTPUT   = 1;
    localparam int POST_GAP     = 2;
    localparam int START_OFFSET = 130;
    localparam int PLANE_OFFSET = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ice40_audio_fc_seq_if bus ();

    ice40_audio_fc_seq #(
        .NUM_OUTPUT(NUM_OUTPUT),
        .POST_GAP(POST_GAP),
        .START_OFFSET(START_OFFSET),
        .PLANE_OFFSET(PLANE_OFFSET)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_blk_q[$];    // block index seen at each INIT_BIAS entry
    logic [31:0] exp_round_q[$];  // {run_len[31:16], rd_len[15:0]}
    logic [53:0] exp_done_q[$];   // {cycles[53:22], bias[21:16], shifts[15:8], blk[7:0]}
    int          stall_q[$];      // rd_rdy stall length per INIT_BIAS visit
    int          waited = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a run is (np+1) planes x (nc+1) chunks x (nr+1) rounds.
    // Plane 0 starts at blk-START_OFFSET, later planes at blk-PLANE_OFFSET,
    // each chunk moves by stride. Every round spends stall+1 cycles waiting
    // for data and eff_nd+3 cycles running, followed by one address step.
    task automatic expect_run(input int nd, input int nr, input int nc, input int np,
                              input logic [7:0] stride, input logic [7:0] blk,
                              input int max_stall, input int first_stall);
        int eff_nd = (nd == 0) ? 1 : nd;
        int rounds = (nr + 1) * (nc + 1) * (np + 1);
        int g = NUM_OUTPUT + POST_GAP;
        int ib_cycles = 0;
        int visit = 0;
        int s;
        int cyc;
        logic [7:0] base;
        for (int p = 0; p <= np; p++) begin
            base = (p == 0) ? blk - 8'(START_OFFSET) : blk - 8'(PLANE_OFFSET);
            for (int c = 0; c <= nc; c++) begin
                for (int r = 0; r <= nr; r++) begin
                    exp_blk_q.push_back(base + 8'(c) * stride);
                    exp_round_q.push_back({16'(eff_nd + 3), 16'(eff_nd)});
                    s = (visit == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(max_stall, 0));
                    stall_q.push_back(s);
                    ib_cycles += s + 1;
                    visit++;
                end
            end
        end
        cyc = ib_cycles + rounds * (eff_nd + 4) + (np + 1) + ((g >= 2) ? g - 1 : 1);
        exp_done_q.push_back({32'(cyc), 6'(ib_cycles), 8'(rounds * NUM_OUTPUT),
                              blk - 8'(PLANE_OFFSET)});
    endtask

    // Called at a negedge with the DUT idle; config is scrambled right after acceptance
    task automatic start_run(input int nd, input int nr, input int nc, input int np,
                             input logic [7:0] stride, input logic [7:0] blk);
        bus.i_cfg_num_data  = 12'(nd);
        bus.i_cfg_num_round = 6'(nr);
        bus.i_cfg_num_chunk = 6'(nc);
        bus.i_cfg_num_plane = 2'(np);
        bus.i_cfg_stride    = stride;
        bus.i_blk_idx       = blk;
        bus.i_start         = 1'b1;
        @(negedge clk);
        bus.i_start         = 1'b0;
        bus.i_cfg_num_data  = 12'($urandom_range(4095, 0));
        bus.i_cfg_num_round = 6'($urandom_range(63, 0));
        bus.i_cfg_num_chunk = 6'($urandom_range(63, 0));
        bus.i_cfg_num_plane = 2'($urandom_range(3, 0));
        bus.i_cfg_stride    = 8'($urandom_range(255, 0));
        bus.i_blk_idx       = 8'($urandom_range(255, 0));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.o_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus.o_done, 1);
    endtask

    // HOLD -> IDLE takes one cycle once i_start is low
    task automatic leave_hold();
        repeat (2) @(negedge clk);
    endtask

    // Input buffer model: answers o_rd_req after the queued number of stall cycles
    initial begin
        bus.i_rd_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_rd_req) begin
                if (stall_q.size() == 0 || waited >= stall_q[0]) begin
                    bus.i_rd_rdy = 1'b1;
                    waited = 0;
                    if (stall_q.size() != 0) void'(stall_q.pop_front());
                end else begin
                    bus.i_rd_rdy = 1'b0;
                    waited++;
                end
            end else begin
                bus.i_rd_rdy = 1'($urandom_range(1, 0));
            end
        end
    end

    // Monitor: checks block index on each INIT_BIAS entry, round lengths on
    // each RUN_ROUND exit and run totals on arrival in HOLD
    logic        prev_rd_req = 1'b0, prev_run = 1'b0, prev_done = 1'b0;
    int          run_len = 0, rd_len = 0, wgt_len = 0, shifts = 0, aborts = 0;
    logic [31:0] rr;
    logic [53:0] dd;
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            run_len = 0; rd_len = 0; wgt_len = 0; shifts = 0; aborts = 0;
        end else begin
            if (bus.o_fc_run)      run_len++;
            if (bus.o_input_rd)    rd_len++;
            if (bus.o_wgt_rd)      wgt_len++;
            if (bus.o_fc_ps_shift) shifts++;
            if (bus.o_aborted)     aborts++;
            if (bus.o_rd_req && !prev_rd_req) begin
                if (exp_blk_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL blk_unexpected: INIT_BIAS entry with no expected block");
                end else chk("blk_idx", bus.o_blk_idx, exp_blk_q.pop_front());
            end
            if (!bus.o_fc_run && prev_run) begin
                if (exp_round_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL round_unexpected: round end with no expected round");
                end else begin
                    rr = exp_round_q.pop_front();
                    chk("round_len", run_len, rr[31:16]);
                    chk("input_rd_len", rd_len, rr[15:0]);
                    chk("wgt_rd_len", wgt_len, rr[15:0]);
                end
                run_len = 0; rd_len = 0; wgt_len = 0;
            end
            if (bus.o_done && !prev_done) begin
                if (exp_done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: HOLD with no expected run");
                end else begin
                    dd = exp_done_q.pop_front();
                    chk("done_cycles", bus.o_cycles, dd[53:22]);
                    chk("done_bias_addr", bus.o_bias_addr, dd[21:16]);
                    chk("done_shifts", shifts, dd[15:8]);
                    chk("done_blk_idx", bus.o_blk_idx, dd[7:0]);
                    chk("done_no_abort", aborts, 0);
                end
                shifts = 0; aborts = 0;
            end
        end
        prev_rd_req = bus.o_rd_req;
        prev_run    = bus.o_fc_run;
        prev_done   = bus.o_done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n;
    logic [31:0] cyc_snap;
    initial begin
        reset = 1'b1;
        bus.i_start = 1'b0; bus.i_repeat_run = 1'b0; bus.i_abort = 1'b0;
        bus.i_cfg_num_data = '0; bus.i_cfg_num_round = '0; bus.i_cfg_num_chunk = '0;
        bus.i_cfg_num_plane = '0; bus.i_cfg_stride = '0; bus.i_blk_idx = '0;
        repeat (3) @(negedge clk);
        chk("rst_init", bus.o_init, 1);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_blk_idx", bus.o_blk_idx, 0);
        chk("rst_cycles", bus.o_cycles, 0);
        chk("rst_bias_addr", bus.o_bias_addr, 0);
        chk("rst_input_rd", bus.o_input_rd, 0);
        chk("rst_aborted", bus.o_aborted, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Baseline single-plane run
        expect_run(4, 1, 1, 0, 8'd2, 8'd200, 0, 0);
        start_run(4, 1, 1, 0, 8'd2, 8'd200);
        wait_done("t1_done");
        chk("t1_cycles", bus.o_cycles, 39);
        chk("t1_bias_addr", bus.o_bias_addr, 4);
        leave_hold();

        // Two planes: second plane restarts from blk-128
        expect_run(4, 1, 1, 1, 8'd2, 8'd200, 0, 0);
        start_run(4, 1, 1, 1, 8'd2, 8'd200);
        wait_done("t2_done");
        leave_hold();

        // Five-cycle rd_rdy stall on the first INIT_BIAS visit
        expect_run(4, 1, 1, 0, 8'd2, 8'd200, 0, 5);
        start_run(4, 1, 1, 0, 8'd2, 8'd200);
        wait_done("t3_done");
        chk("t3_cycles", bus.o_cycles, 44);
        chk("t3_bias_addr", bus.o_bias_addr, 9);
        leave_hold();

        // Abort on the third RUN_ROUND cycle
        mon_en = 1'b0;
        start_run(4, 1, 1, 0, 8'd2, 8'd200);
        n = 0;
        while (!bus.o_fc_run && n < 50) begin @(negedge clk); n++; end
        chk("abort_reach_run", bus.o_fc_run, 1);
        repeat (2) @(negedge clk);
        chk("abort_rd_before", bus.o_input_rd, 1);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_init", bus.o_init, 1);
        chk("abort_pulse", bus.o_aborted, 1);
        chk("abort_input_rd", bus.o_input_rd, 0);
        chk("abort_wgt_rd", bus.o_wgt_rd, 0);
        chk("abort_ps_shift", bus.o_fc_ps_shift, 0);
        cyc_snap = bus.o_cycles;
        bus.i_abort = 1'b1;  // abort while idle must be ignored
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("abort_pulse_single", bus.o_aborted, 0);
        repeat (3) @(negedge clk);
        chk("abort_cycles_frozen", bus.o_cycles, cyc_snap);
        chk("abort_still_idle", bus.o_init, 1);
        mon_en = 1'b1;

        // Clean restart after abort
        expect_run(4, 1, 1, 0, 8'd2, 8'd200, 0, 0);
        start_run(4, 1, 1, 0, 8'd2, 8'd200);
        wait_done("t5_done");
        chk("t5_cycles", bus.o_cycles, 39);
        leave_hold();

        // i_start held: stay in HOLD, then repeat_run releases an immediate restart
        expect_run(2, 0, 1, 0, 8'd5, 8'd10, 0, 0);
        expect_run(2, 0, 1, 0, 8'd5, 8'd10, 0, 0);
        bus.i_cfg_num_data = 12'd2; bus.i_cfg_num_round = 6'd0; bus.i_cfg_num_chunk = 6'd1;
        bus.i_cfg_num_plane = 2'd0; bus.i_cfg_stride = 8'd5; bus.i_blk_idx = 8'd10;
        bus.i_start = 1'b1;
        @(negedge clk);
        wait_done("t6_done_first");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_hold_stays", bus.o_done, 1);
        end
        bus.i_repeat_run = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_hold", bus.o_init, 1);
        @(negedge clk);
        chk("t6_restart", bus.o_rd_req, 1);
        bus.i_start = 1'b0;
        bus.i_repeat_run = 1'b0;
        wait_done("t6_done_second");
        leave_hold();

        // num_data of zero behaves as one
        expect_run(0, 1, 0, 0, 8'd1, 8'd0, 0, 0);
        start_run(0, 1, 0, 0, 8'd1, 8'd0);
        wait_done("t7_done");
        leave_hold();

        // Reset in the middle of a run
        mon_en = 1'b0;
        start_run(4, 1, 1, 0, 8'd2, 8'd200);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", bus.o_busy, 0);
        chk("mid_rst_blk_idx", bus.o_blk_idx, 0);
        chk("mid_rst_cycles", bus.o_cycles, 0);
        chk("mid_rst_bias_addr", bus.o_bias_addr, 0);
        chk("mid_rst_input_rd", bus.o_input_rd, 0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Randomized runs with random stalls
        for (int k = 0; k < 8; k++) begin
            int nd, nr, nc, np;
            logic [7:0] st, bk;
            nd = $urandom_range(12, 0);
            nr = $urandom_range(2, 0);
            nc = $urandom_range(2, 0);
            np = $urandom_range(1, 0);
            st = 8'($urandom_range(255, 0));
            bk = 8'($urandom_range(255, 0));
            expect_run(nd, nr, nc, np, st, bk, 3, -1);
            start_run(nd, nr, nc, np, st, bk);
            wait_done("rand_done");
            leave_hold();
        end

        chk("exp_queues_empty", exp_blk_q.size() + exp_round_q.size() + exp_done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ice40_audio_fc_seq.md
Name: ice40_audio_fc_seq

Overview:
Parametrised, runtime-configurable successor to the keyword-spotting fully-connected layer control unit. Sequences bias init, round/chunk/plane loops, input/weight read strobes and partial-sum shift pulses for the FC MAC array. Loop bounds and stride are latched from config ports at start, so one bitstream serves both 64x64x1 and 32x32x2 front-ends. Adds abort, busy/aborted status and a programmable output count.

Parameters:
DATA_W, 12, width of num_data and data counter
CNT_W, 6, width of round/chunk counters and bias address
BLK_W, 8, block index width (modulo-2^BLK_W arithmetic)
NUM_OUTPUT, 1, ps-shift pulses per round (1..15)
POST_GAP, 2, extra drain cycles after shifts (0..14; NUM_OUTPUT+POST_GAP <= 15)
START_OFFSET, 130, first-plane block offset subtracted from i_blk_idx
PLANE_OFFSET, 128, later-plane block offset subtracted from start index
CYC_W, 32, cycle counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_start  in  1  level start; accepted in IDLE
i_repeat_run  in  1  1 = leave HOLD even while i_start is high
i_abort  in  1  abort current run
i_cfg_num_data  in  DATA_W  data words per round
i_cfg_num_round  in  CNT_W  rounds per chunk minus 1
i_cfg_num_chunk  in  CNT_W  chunks per plane minus 1
i_cfg_num_plane  in  2  planes minus 1
i_cfg_stride  in  BLK_W  block increment per chunk
i_blk_idx  in  BLK_W  current write block index
i_rd_rdy  in  1  input buffer ready
o_rd_req  out  1  read request (state INIT_BIAS)
o_blk_idx  out  BLK_W  read block index
o_cycles  out  CYC_W  busy cycle count
o_bias_addr  out  CNT_W  bias address
o_init, o_rst_raddr, o_rst_waddr, o_rst_wgt_addr  out  1 each  control strobes
o_fc_run  out  1  state RUN_ROUND
o_input_rd, o_wgt_rd  out  1 each  read enables (registered)
o_init_bias  out  1  registered copy of (state==INIT_BIAS)
o_fc_ps_shift  out  1  partial-sum shift
o_busy  out  1  state not IDLE/HOLD
o_done  out  1  state HOLD
o_aborted  out  1  one-cycle pulse after abort

Behaviour:
- Reset: state IDLE; all counters, registered outputs, o_blk_idx, o_cycles and o_aborted = 0.
- States: IDLE, INIT_BIAS, RUN_ROUND, RST_ADDR, NEXT_CHUNK, NEXT_PLANE, WAIT_WRITE, HOLD.
- Transitions:
  - IDLE -> INIT_BIAS on i_start.
  - INIT_BIAS -> RUN_ROUND when i_rd_rdy; otherwise stay.
  - RUN_ROUND on round_done -> NEXT_CHUNK if round_cnt==num_round, else RST_ADDR.
  - RST_ADDR -> INIT_BIAS.
  - NEXT_CHUNK -> NEXT_PLANE if chunk_cnt==num_chunk, else INIT_BIAS.
  - NEXT_PLANE -> WAIT_WRITE if plane_cnt==num_plane, else INIT_BIAS.
  - WAIT_WRITE -> HOLD when output_cnt==0.
  - HOLD -> IDLE unless (i_start && !i_repeat_run).
- Config: latched in IDLE on the i_start cycle, held stable for the whole run. A latched num_data of 0 is forced to 1.
- On start acceptance: start_blk = i_blk_idx; o_blk_idx = i_blk_idx - START_OFFSET; o_cycles = 0.
- Block index updates: NEXT_CHUNK adds stride; NEXT_PLANE loads start_blk - PLANE_OFFSET. All arithmetic is modulo 2^BLK_W.
- Loop counters:
  - round_cnt clears in IDLE/NEXT_CHUNK, increments in RST_ADDR.
  - chunk_cnt clears in IDLE/NEXT_PLANE, increments in NEXT_CHUNK.
  - plane_cnt increments in NEXT_PLANE.
- Round timing:
  - data_cnt clears in IDLE/INIT_BIAS and increments in RUN_ROUND.
  - round_done = (data_cnt == num_data+2), so RUN_ROUND lasts num_data+3 cycles.
  - o_input_rd/o_wgt_rd set at data_cnt==0 and clear at data_cnt==num_data, i.e. high for exactly num_data cycles starting one cycle after RUN_ROUND entry. Both forced 0 outside RUN_ROUND.
- Output drain:
  - output_cnt loads NUM_OUTPUT+POST_GAP on round_done, then decrements to 0.
  - o_fc_ps_shift (registered) = output_cnt!=0 && output_cnt<=NUM_OUTPUT, giving NUM_OUTPUT pulses per round.
- o_bias_addr: clears in IDLE, increments each cycle o_init_bias is high.
- o_cycles: increments in every non-IDLE, non-HOLD cycle; frozen otherwise.
- Strobes:
  - o_init = IDLE.
  - o_rst_raddr = IDLE | RST_ADDR.
  - o_rst_waddr = IDLE | (WAIT_WRITE & output_cnt==0).
  - o_rst_wgt_addr = IDLE | NEXT_CHUNK.
- Abort: i_abort in any state other than IDLE/HOLD -> IDLE next cycle. Read strobes, o_fc_ps_shift and output_cnt clear; o_aborted pulses 1 cycle; o_cycles holds its value. i_abort in IDLE/HOLD is ignored. If abort and round_done coincide, abort wins.
- reset mid-run returns everything to reset values at the next edge.

Test Plan:
- Config data=4, round=1, chunk=1, plane=0, stride=2, blk_idx=200, rdy=1, NUM_OUTPUT=1, POST_GAP=2 -> o_blk_idx 70 then 72; 4 INIT_BIAS pulses; o_bias_addr ends at 4; o_input_rd high 4 cycles per round; 4 ps-shift pulses; o_cycles=39 at HOLD.
- Same config with plane=1 -> after NEXT_PLANE o_blk_idx=72 (200-128); 8 rounds total; o_done only after second plane.
- i_rd_rdy held low 5 cycles in INIT_BIAS -> o_rd_req high 6 cycles; o_bias_addr advances by 6; o_cycles counts the stall.
- i_abort asserted on the 3rd RUN_ROUND cycle -> IDLE next cycle; o_aborted single pulse; o_input_rd=0; o_cycles frozen; a new start restarts cleanly.
- i_start held high with i_repeat_run=0 -> stays in HOLD; with i_repeat_run=1 -> HOLD then IDLE then immediate restart.
- i_cfg_num_data=0 -> treated as 1: RUN_ROUND 4 cycles, o_input_rd 1 cycle; changing config mid-run has no effect.
